// File: rtl/rll_key_sequencer.sv
// Key-load controller for RLL-locked netlists: fetches the key word-by-word over req/ack,
// verifies it and presents it atomically. Optional checksum/retry via `RLL_KEY_CHECKSUM_EN.
module rll_key_sequencer #(
   parameter int KEY_W     = 16,
   parameter int WORD_W    = 4,
   parameter int MAX_RETRY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              rom_req,
   output logic [2:0]        rom_addr,
   input  logic              rom_ack,
   input  logic [WORD_W-1:0] rom_data,
   output logic [KEY_W-1:0]  key_out,
   output logic              key_valid,
   output logic              busy,
   output logic              err
);

   localparam int NWORDS = KEY_W / WORD_W;
`ifdef RLL_KEY_CHECKSUM_EN
   localparam logic [2:0] LAST_ADDR = 3'(NWORDS);
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`else
   localparam logic [2:0] LAST_ADDR = 3'(NWORDS - 1);
`endif

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_CHECK, S_DONE, S_FAIL} state_t;

   state_t             state, state_nxt;
   logic [KEY_W-1:0]   shadow;
   logic               load_start, word_take, do_retry, go_done;
`ifdef RLL_KEY_CHECKSUM_EN
   logic [WORD_W-1:0]  xor_acc, chk_word;
   logic [RETRY_W-1:0] retry;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      load_start = 1'b0;
      word_take  = 1'b0;
      do_retry   = 1'b0;
      go_done    = 1'b0;
      rom_req    = 1'b0;
      busy       = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               state_nxt  = S_REQ;
               load_start = 1'b1;
            end
         end
         S_REQ: begin
            rom_req = 1'b1;
            busy    = 1'b1;
            if (rom_ack) begin
               word_take = 1'b1;
               if (rom_addr == LAST_ADDR) state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            busy = 1'b1;
`ifdef RLL_KEY_CHECKSUM_EN
            if (xor_acc == chk_word) begin
               state_nxt = S_DONE;
               go_done   = 1'b1;
            end else if (retry < RETRY_W'(MAX_RETRY)) begin
               state_nxt = S_REQ;
               do_retry  = 1'b1;
            end else begin
               state_nxt = S_FAIL;
            end
`else
            state_nxt = S_DONE;
            go_done   = 1'b1;
`endif
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Words land in the shadow register; key_out only ever sees zero or a verified shadow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr  <= '0;
         shadow    <= '0;
         key_out   <= '0;
         key_valid <= 1'b0;
      end else if (load_start) begin
         rom_addr  <= '0;
         shadow    <= '0;
         key_out   <= '0;
         key_valid <= 1'b0;
      end else if (word_take) begin
         for (int w = 0; w < NWORDS; w++) begin
            if (rom_addr == 3'(w)) shadow[w*WORD_W +: WORD_W] <= rom_data;
         end
         rom_addr <= rom_addr + 3'd1;
      end else if (do_retry) begin
         rom_addr <= '0;
         shadow   <= '0;
      end else if (go_done) begin
         key_out   <= shadow;
         key_valid <= 1'b1;
      end
   end

`ifdef RLL_KEY_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xor_acc  <= '0;
         chk_word <= '0;
         retry    <= '0;
         err      <= 1'b0;
      end else if (load_start) begin
         xor_acc  <= '0;
         chk_word <= '0;
         retry    <= '0;
         err      <= 1'b0;
      end else if (word_take) begin
         if (rom_addr < 3'(NWORDS)) xor_acc  <= xor_acc ^ rom_data;
         else                       chk_word <= rom_data;
      end else if (do_retry) begin
         retry   <= retry + RETRY_W'(1);
         xor_acc <= '0;
      end else if (state_nxt == S_FAIL) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule
